hlsm_job_driver: RTL and testbench
==================================

Name: hlsm_job_driver

Overview:
- Initiator-side controller for the Start/Done handshake used by the team's HLSM datapath blocks; the first target is the 8-input signed averager.
- Accepts jobs from an upstream valid/ready channel. Each job carries eight signed 8-bit operands and a divisor.
- Holds the operands stable on the accelerator bus, pulses Start, and detects completion. It then captures the result and returns it on a downstream valid/ready channel.
- Completion detection copes with a Done output that stays high once set.

Parameters:
- N_OPS, 8, number of operands per job.
- DW, 8, operand, divisor and result width in bits (signed).
- LATENCY, 10, cycles from the Start-high cycle to the point where the accelerator result is guaranteed valid. This is the fallback completion condition.
- CW, 16, width of the completed-job counter.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Rst  in  1  asynchronous, active-high reset.
- InValid  in  1  upstream job valid.
- InReady  out  1  driver can accept a job.
- InOps  in  N_OPS*DW  packed operands; operand 0 in bits [DW-1:0].
- InNum  in  DW  divisor.
- Start  out  1  one-cycle pulse to the accelerator.
- OpBus  out  N_OPS*DW  registered operands driven to the accelerator.
- Num  out  DW  registered divisor driven to the accelerator.
- Done  in  1  accelerator done; may remain high after the first job.
- Avg  in  DW  accelerator result.
- OutValid  out  1  result valid.
- OutReady  in  1  downstream accepts the result.
- OutAvg  out  DW  captured result.
- OutErr  out  1  job had divisor 0; accelerator was not started.
- JobCount  out  CW  number of results accepted downstream.

Behaviour:
- Reset (asynchronous, Rst=1) forces:
  - state IDLE;
  - InReady=0 while Rst is asserted;
  - Start=0, OutValid=0, OutErr=0;
  - OutAvg=0, OpBus=0, Num=0, JobCount=0;
  - elapsed counter and DonePrev cleared.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - InReady=1.
  - On InValid&InReady, latch InOps into OpBus and InNum into Num.
  - If InNum==0: set OutAvg=0 and OutErr=1, go to RESP. The accelerator is never started.
  - Otherwise: set OutErr=0, go to ISSUE.
- ISSUE:
  - Start=1 for exactly this one cycle.
  - Clear the elapsed counter.
  - Record DonePrev=Done.
  - Go to WAIT.
- WAIT:
  - Start=0; the elapsed counter increments each cycle.
  - Completion occurs when either:
    - a rising edge of Done is seen (Done=1 and DonePrev=0); or
    - elapsed reaches LATENCY-1, i.e. LATENCY cycles after the Start cycle.
  - On completion, capture Avg into OutAvg and go to RESP.
  - DonePrev updates every WAIT cycle.
- RESP:
  - OutValid=1; OutAvg and OutErr are held stable.
  - On OutReady=1: clear OutValid, increment JobCount (wraps modulo 2^CW), go to IDLE.
- InReady is 1 only in IDLE. At most one job is in flight; there is no buffering.
- OpBus and Num change only on job acceptance. They stay constant from ISSUE through RESP.
- Cycle timing:
  - Accept-to-Start is 1 cycle.
  - Minimum Start-to-OutValid latency is LATENCY+1 cycles when Done stays high. It is shorter if a Done rising edge arrives first.
- Simultaneous events:
  - A rising edge of Done on the same cycle that elapsed reaches its limit counts as one completion; the result is captured once.
  - OutReady asserted before OutValid has no effect.
- Rst asserted mid-job abandons the job immediately. No Start pulse, OutValid or JobCount change follows reset release until a new job is accepted.
- Done or Avg activity in IDLE or RESP is ignored.

Decomposition:
- Shared package (hlsm_pkg): state encoding constants (IDLE, ISSUE, WAIT, RESP) and defaults for DW, N_OPS and LATENCY, so driver and accelerator agree on them.
- One natural sub-module: hlsm_done_detect. It holds the DonePrev register, the elapsed counter, and the rising-edge-or-latency compare, and outputs a single completion pulse.
- The FSM and datapath registers stay in hlsm_job_driver.

Test Plan:
1. Basic job: ops 1..8 and num=4, with the averager attached.
   - Start pulses exactly once, 1 cycle after acceptance.
   - OutAvg=9 (36/4), OutErr=0, JobCount=1.
2. Divide-by-zero: num=0, ops any.
   - No Start pulse.
   - OutValid on the cycle after acceptance, with OutAvg=0, OutErr=1.
3. Sticky Done: run a second job (ops all 10, num=8) while Done is still 1.
   - Completion comes via the latency fallback.
   - OutValid exactly LATENCY+1 cycles after Start; OutAvg=10; JobCount=2.
4. Backpressure: hold OutReady=0 for 20 cycles.
   - OutValid and OutAvg stay stable; InReady=0 throughout.
   - After OutReady=1, InReady=1 on the next cycle.
5. Reset mid-WAIT: assert Rst 3 cycles after Start.
   - All outputs are zero immediately (asynchronously).
   - After release: no OutValid, JobCount=0.
6. Negative operands: all ops=-16, num=2.
   - Signed sum -128, so OutAvg=-64 (8'hC0).
   - OpBus is unchanged during WAIT.

Source files
------------

// File: rtl/hlsm_pkg.sv
// hlsm_pkg: shared state encoding and default sizing for HLSM driver and accelerator blocks.
package hlsm_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int N_OPS_DEF   = 8;
    localparam int DW_DEF      = 8;
    localparam int LATENCY_DEF = 10;
    localparam int CW_DEF      = 16;
endpackage

// File: rtl/hlsm_job_driver_if.sv
// hlsm_job_driver_if: job, accelerator and result channels of the HLSM job driver.
interface hlsm_job_driver_if #(
    parameter int N_OPS = 8,
    parameter int DW    = 8,
    parameter int CW    = 16
);
    logic                InValid;
    logic                InReady;
    logic [N_OPS*DW-1:0] InOps;
    logic [DW-1:0]       InNum;
    logic                Start;
    logic [N_OPS*DW-1:0] OpBus;
    logic [DW-1:0]       Num;
    logic                Done;
    logic [DW-1:0]       Avg;
    logic                OutValid;
    logic                OutReady;
    logic [DW-1:0]       OutAvg;
    logic                OutErr;
    logic [CW-1:0]       JobCount;
    modport master (
        input  InValid, InOps, InNum, Done, Avg, OutReady,
        output InReady, Start, OpBus, Num, OutValid, OutAvg, OutErr, JobCount
    );
    modport slave (
        output InValid, InOps, InNum, Done, Avg, OutReady,
        input  InReady, Start, OpBus, Num, OutValid, OutAvg, OutErr, JobCount
    );
endinterface

// File: rtl/hlsm_done_detect.sv
// hlsm_done_detect: completion pulse on a Done rising edge or once LATENCY cycles have elapsed since Start.
module hlsm_done_detect #(
    parameter int LATENCY = 10
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr,
    input  logic en,
    input  logic done,
    output logic cmpl
);
    localparam int EW = $clog2(LATENCY + 1);
    logic [EW-1:0] elapsed;
    logic          done_prev;
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            elapsed   <= '0;
            done_prev <= 1'b0;
        end else if (clr) begin
            elapsed   <= '0;
            done_prev <= done;
        end else if (en) begin
            elapsed   <= elapsed + 1'b1;
            done_prev <= done;
        end
    end
    // A sticky Done never produces an edge, so the elapsed limit is the backstop.
    assign cmpl = en && ((done && !done_prev) || elapsed == EW'(LATENCY - 1));
endmodule

// File: rtl/hlsm_job_driver.sv
// hlsm_job_driver: accepts operand jobs, runs one accelerator Start/Done handshake per job and returns the result.
module hlsm_job_driver
    import hlsm_pkg::*;
#(
    parameter int N_OPS   = N_OPS_DEF,
    parameter int DW      = DW_DEF,
    parameter int LATENCY = LATENCY_DEF,
    parameter int CW      = CW_DEF
) (
    input logic               Clk,
    input logic               Rst,
    hlsm_job_driver_if.master bus
);
    state_t state, state_nx;
    logic   accept, zero_div, cmpl;
    assign accept   = bus.InValid && bus.InReady;
    assign zero_div = bus.InNum == '0;
    hlsm_done_detect #(.LATENCY(LATENCY)) u_done (
        .Clk  (Clk),
        .Rst  (Rst),
        .clr  (state == ISSUE),
        .en   (state == WAIT),
        .done (bus.Done),
        .cmpl (cmpl)
    );
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !accept ? IDLE : (zero_div ? RESP : ISSUE);
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = cmpl ? RESP : WAIT;
            RESP:    state_nx = bus.OutReady ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    assign bus.InReady  = (state == IDLE) && !Rst;
    assign bus.Start    = state == ISSUE;
    assign bus.OutValid = state == RESP;
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bus.OpBus    <= '0;
            bus.Num      <= '0;
            bus.OutAvg   <= '0;
            bus.OutErr   <= 1'b0;
            bus.JobCount <= '0;
        end else begin
            if (accept) begin
                bus.OpBus  <= bus.InOps;
                bus.Num    <= bus.InNum;
                bus.OutErr <= zero_div;
                if (zero_div) bus.OutAvg <= '0;
            end
            if (state == WAIT && cmpl) bus.OutAvg <= bus.Avg;
            if (state == RESP && bus.OutReady) bus.JobCount <= bus.JobCount + 1'b1;
        end
    end
endmodule

// File: tb/tb_hlsm_job_driver.sv
// tb_hlsm_job_driver: directed checks of the job driver against a behavioural averager.
module tb_hlsm_job_driver;
    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    int         checks = 0;
    int         failures = 0;
    int         start_cnt = 0;
    int         acc_delay = 3;
    logic       done_sticky = 1'b1;
    logic [3:0] acc_cnt;
    logic [7:0] acc_res;
    hlsm_job_driver_if #(.N_OPS(8), .DW(8), .CW(16)) bus();
    hlsm_job_driver #(.N_OPS(8), .DW(8), .LATENCY(10), .CW(16)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );
    always #5 Clk = ~Clk;
    always @(posedge Clk) if (bus.Start === 1'b1) start_cnt++;

    function automatic logic [7:0] avg8(input logic [63:0] ops, input logic [7:0] num);
        int s = 0;
        for (int i = 0; i < 8; i++) s += int'($signed(ops[i*8 +: 8]));
        return 8'(s / int'($signed(num)));
    endfunction

    // Averager stand-in: result and Done appear acc_delay cycles after Start; Done is sticky unless told otherwise.
    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bus.Done <= 1'b0;
            bus.Avg  <= '0;
            acc_cnt  <= '0;
            acc_res  <= '0;
        end else if (bus.Start) begin
            acc_cnt <= 4'(acc_delay);
            acc_res <= avg8(bus.OpBus, bus.Num);
            if (!done_sticky) bus.Done <= 1'b0;
        end else if (acc_cnt != 0) begin
            acc_cnt <= acc_cnt - 1'b1;
            if (acc_cnt == 1) begin
                bus.Avg  <= acc_res;
                bus.Done <= 1'b1;
            end
        end
    end

    function automatic logic [63:0] fill(input logic [7:0] v);
        return {8{v}};
    endfunction

    task automatic issue(input logic [63:0] ops, input logic [7:0] num);
        int n = 0;
        while (bus.InReady !== 1'b1 && n < 50) begin @(posedge Clk); #1; n++; end
        bus.InValid = 1'b1;
        bus.InOps   = ops;
        bus.InNum   = num;
        @(posedge Clk); #1;
        bus.InValid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.OutValid !== 1'b1 && n < 40) begin @(posedge Clk); #1; n++; end
        if (bus.OutValid !== 1'b1) n = -1;
    endtask

    task automatic ack();
        bus.OutReady = 1'b1;
        @(posedge Clk); #1;
        bus.OutReady = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge Clk); #1;
        checks++;
        if ({bus.InReady, bus.Start, bus.OutValid, bus.OutErr} !== 4'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0000", {bus.InReady, bus.Start, bus.OutValid, bus.OutErr});
        end
        checks++;
        if ({bus.OutAvg, bus.OpBus, bus.Num, bus.JobCount} !== '0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {bus.OutAvg, bus.OpBus, bus.Num, bus.JobCount});
        end
        Rst = 1'b0;
        #1;
        checks++;
        if (bus.InReady !== 1'b1) begin failures++; $display("FAIL reset_inready got=%b exp=1", bus.InReady); end
    endtask

    task automatic test_basic();
        logic [63:0] ops;
        int s0, n;
        for (int i = 0; i < 8; i++) ops[i*8 +: 8] = 8'(i + 1);
        s0 = start_cnt;
        issue(ops, 8'd4);
        checks++;
        if (bus.Start !== 1'b1) begin failures++; $display("FAIL basic_start got=%b exp=1", bus.Start); end
        wait_valid(n);
        checks++;
        if (n !== 5) begin failures++; $display("FAIL basic_latency got=%0d exp=5", n); end
        checks++;
        if (bus.OutAvg !== 8'd9 || bus.OutErr !== 1'b0) begin
            failures++; $display("FAIL basic_result got=%0d/%b exp=9/0", bus.OutAvg, bus.OutErr);
        end
        checks++;
        if (start_cnt - s0 !== 1) begin failures++; $display("FAIL basic_start_count got=%0d exp=1", start_cnt - s0); end
        ack();
        checks++;
        if (bus.JobCount !== 16'd1 || bus.OutValid !== 1'b0) begin
            failures++; $display("FAIL basic_jobcount got=%0d/%b exp=1/0", bus.JobCount, bus.OutValid);
        end
    endtask

    task automatic test_sticky();
        int n;
        issue(fill(8'd10), 8'd8);
        checks++;
        if (bus.Start !== 1'b1 || bus.Done !== 1'b1) begin
            failures++; $display("FAIL sticky_start got=%b/%b exp=1/1", bus.Start, bus.Done);
        end
        bus.OutReady = 1'b1;
        @(posedge Clk); #1;
        bus.OutReady = 1'b0;
        wait_valid(n);
        checks++;
        if (n + 1 !== 11) begin failures++; $display("FAIL sticky_latency got=%0d exp=11", n + 1); end
        checks++;
        if (bus.OutAvg !== 8'd10 || bus.JobCount !== 16'd1) begin
            failures++; $display("FAIL sticky_result got=%0d/%0d exp=10/1", bus.OutAvg, bus.JobCount);
        end
        ack();
        checks++;
        if (bus.JobCount !== 16'd2) begin failures++; $display("FAIL sticky_jobcount got=%0d exp=2", bus.JobCount); end
    endtask

    task automatic test_div_zero();
        int s0, n;
        s0 = start_cnt;
        issue(fill(8'd33), 8'd0);
        wait_valid(n);
        checks++;
        if (n !== 0) begin failures++; $display("FAIL divzero_latency got=%0d exp=0", n); end
        checks++;
        if (bus.OutAvg !== 8'd0 || bus.OutErr !== 1'b1) begin
            failures++; $display("FAIL divzero_result got=%0d/%b exp=0/1", bus.OutAvg, bus.OutErr);
        end
        ack();
        checks++;
        if (start_cnt !== s0 || bus.JobCount !== 16'd3) begin
            failures++; $display("FAIL divzero_nostart got=%0d/%0d exp=%0d/3", start_cnt, bus.JobCount, s0);
        end
    endtask

    task automatic test_backpressure();
        int n, bad;
        issue(fill(8'd5), 8'd5);
        wait_valid(n);
        checks++;
        if (n !== 11) begin failures++; $display("FAIL bp_latency got=%0d exp=11", n); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.OutValid !== 1'b1 || bus.OutAvg !== 8'd8 || bus.InReady !== 1'b0) bad++;
            @(posedge Clk); #1;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL bp_hold got=%0d bad cycles exp=0", bad); end
        ack();
        checks++;
        if (bus.InReady !== 1'b1 || bus.JobCount !== 16'd4) begin
            failures++; $display("FAIL bp_release got=%b/%0d exp=1/4", bus.InReady, bus.JobCount);
        end
    endtask

    task automatic test_reset_mid();
        int s0, bad;
        issue(fill(8'd7), 8'd1);
        repeat (3) begin @(posedge Clk); #1; end
        Rst = 1'b1;
        #1;
        checks++;
        if ({bus.InReady, bus.Start, bus.OutValid, bus.OutErr, bus.OutAvg, bus.OpBus, bus.Num, bus.JobCount} !== '0) begin
            failures++; $display("FAIL midreset_async got=%h exp=0",
                {bus.InReady, bus.Start, bus.OutValid, bus.OutErr, bus.OutAvg, bus.OpBus, bus.Num, bus.JobCount});
        end
        @(posedge Clk); #1;
        Rst = 1'b0;
        s0 = start_cnt;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.OutValid !== 1'b0) bad++;
            @(posedge Clk); #1;
        end
        checks++;
        if (bad !== 0 || start_cnt !== s0 || bus.JobCount !== 16'd0) begin
            failures++; $display("FAIL midreset_quiet got=%0d/%0d/%0d exp=0/%0d/0", bad, start_cnt, bus.JobCount, s0);
        end
    endtask

    task automatic test_negative();
        int n, bad;
        issue(fill(8'hF0), 8'd2);
        n = 0;
        bad = 0;
        while (bus.OutValid !== 1'b1 && n < 40) begin
            if (bus.OpBus !== fill(8'hF0) || bus.Num !== 8'd2) bad++;
            @(posedge Clk); #1;
            n++;
        end
        checks++;
        if (n !== 5) begin failures++; $display("FAIL neg_latency got=%0d exp=5", n); end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL neg_opbus_stable got=%0d bad cycles exp=0", bad); end
        checks++;
        if (bus.OutAvg !== 8'hC0 || bus.OutErr !== 1'b0) begin
            failures++; $display("FAIL neg_result got=%h/%b exp=c0/0", bus.OutAvg, bus.OutErr);
        end
        ack();
        checks++;
        if (bus.JobCount !== 16'd1) begin failures++; $display("FAIL neg_jobcount got=%0d exp=1", bus.JobCount); end
    endtask

    task automatic test_simultaneous();
        int n;
        done_sticky = 1'b0;
        acc_delay   = 9;
        issue(fill(8'd50), 8'd10);
        wait_valid(n);
        checks++;
        if (n !== 11) begin failures++; $display("FAIL simul_latency got=%0d exp=11", n); end
        checks++;
        if (bus.OutAvg !== 8'd40) begin failures++; $display("FAIL simul_result got=%0d exp=40", bus.OutAvg); end
        ack();
        checks++;
        if (bus.JobCount !== 16'd2 || bus.OutValid !== 1'b0 || bus.InReady !== 1'b1) begin
            failures++; $display("FAIL simul_once got=%0d/%b/%b exp=2/0/1", bus.JobCount, bus.OutValid, bus.InReady);
        end
    endtask

    initial begin
        bus.InValid  = 1'b0;
        bus.InOps    = '0;
        bus.InNum    = '0;
        bus.OutReady = 1'b0;
        test_reset();
        test_basic();
        test_sticky();
        test_div_zero();
        test_backpressure();
        test_reset_mid();
        test_negative();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
